// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with synchronous load and a runtime wrap value.
// The wrap value is clamped digit-wise to 9 so every compare is a plain unsigned compare.
module bcd_updown_counter #(
  parameter int DIGITS = 3
) (
  input  logic                ck,
  input  logic                rs_n,
  input  logic                en,
  input  logic                up,
  input  logic                ld,
  input  logic [4*DIGITS-1:0] ld_val,
  input  logic [4*DIGITS-1:0] max_val,
  output logic [4*DIGITS-1:0] q,
  output logic                wrap,
  output logic                ld_err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Increment ripples a carry only through trailing 9 digits.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c && v[4*i +: 4] == 4'd9) begin
        r[4*i +: 4] = 4'd0;
      end else if (c) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        c = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b && v[4*i +: 4] == 4'd0) begin
        r[4*i +: 4] = 4'd9;
      end else if (b) begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        b = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  logic [W-1:0] m_s;
  logic         ld_ok_s;
  logic [W-1:0] q_nxt_s;
  logic         wrap_nxt_s;
  logic         lderr_nxt_s;
  logic [W-1:0] q_r;
  logic         wrap_r;
  logic         lderr_r;

  // Effective wrap value and load acceptance.
  always_comb begin
    m_s     = bcd_clamp(max_val);
    ld_ok_s = bcd_valid(ld_val) && (ld_val <= m_s);
  end

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    q_nxt_s     = q_r;
    wrap_nxt_s  = 1'b0;
    lderr_nxt_s = 1'b0;
    if (ld) begin
      if (ld_ok_s) begin
        q_nxt_s = ld_val;
      end else begin
        lderr_nxt_s = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (q_r >= m_s) begin
          q_nxt_s    = {W{1'b0}};
          wrap_nxt_s = 1'b1;
        end else begin
          q_nxt_s = bcd_inc(q_r);
        end
      end else begin
        if (q_r == {W{1'b0}}) begin
          q_nxt_s    = m_s;
          wrap_nxt_s = 1'b1;
        end else if (q_r > m_s) begin
          q_nxt_s = m_s;
        end else begin
          q_nxt_s = bcd_dec(q_r);
        end
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State and pulse registers with synchronous active-low reset.
  always_ff @(posedge ck) begin
    if (!rs_n) begin
      q_r     <= {W{1'b0}};
      wrap_r  <= 1'b0;
      lderr_r <= 1'b0;
    end else begin
      q_r     <= q_nxt_s;
      wrap_r  <= wrap_nxt_s;
      lderr_r <= lderr_nxt_s;
    end
  end

  assign q      = q_r;
  assign wrap   = wrap_r;
  assign ld_err = lderr_r;

endmodule
